// File: rtl/ahb_seq_pkg.sv
// Shared definitions for the AHB burst sequencer: burst codes, FSM states and
// helpers that decode a burst code into beat count and wrap geometry.
package ahb_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 11;

  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [2:0] BURST_WRAP4  = 3'b010;
  localparam logic [2:0] BURST_INCR4  = 3'b011;
  localparam logic [2:0] BURST_WRAP8  = 3'b100;
  localparam logic [2:0] BURST_INCR8  = 3'b101;
  localparam logic [2:0] BURST_WRAP16 = 3'b110;
  localparam logic [2:0] BURST_INCR16 = 3'b111;

  // Last byte offset inside one 1KB slave window.
  localparam logic [10:0] SLAVE_BOUNDARY = 11'd1023;

  typedef enum logic [1:0] {
    StIdle,
    StBeat,
    StWstall,
    StDone
  } seq_state_e;

  function automatic logic [4:0] burst_beats(input logic [2:0] burst, input logic [4:0] len);
    logic [4:0] beats;
    case (burst)
      BURST_SINGLE:               beats = 5'd1;
      BURST_INCR:                 beats = len;
      BURST_WRAP4, BURST_INCR4:   beats = 5'd4;
      BURST_WRAP8, BURST_INCR8:   beats = 5'd8;
      default:                    beats = 5'd16;
    endcase
    return beats;
  endfunction

  function automatic logic is_wrap(input logic [2:0] burst);
    return (burst == BURST_WRAP4) || (burst == BURST_WRAP8) || (burst == BURST_WRAP16);
  endfunction

  // Low address bits that rotate inside a wrapping burst; zero for INCR types.
  function automatic logic [3:0] wrap_mask(input logic [2:0] burst);
    logic [3:0] mask;
    case (burst)
      BURST_WRAP4:  mask = 4'h3;
      BURST_WRAP8:  mask = 4'h7;
      BURST_WRAP16: mask = 4'hF;
      default:      mask = 4'h0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahb_seq_wfifo.sv
// Write-data FIFO for the burst sequencer. Pointers carry one extra wrap bit
// so that occupancy is their difference; pushes when full are dropped.
module ahb_seq_wfifo
  import ahb_seq_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      head,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int unsigned AW = $clog2(Depth);

  logic [DATA_W-1:0] mem_q [Depth];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == (AW + 1)'(Depth));
  assign empty   = (wr_ptr_q == rd_ptr_q);
  // Fullness is judged before any same-cycle pop.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_burst_sequencer.sv
// Command front end for the AHB system top: expands one burst command into
// per-beat byte addresses, paces beats on hready and returns read bytes.
module ahb_burst_sequencer
  import ahb_seq_pkg::*;
#(
  parameter int unsigned WFIFO_DEPTH  = 8,
  parameter int unsigned MAX_INCR_LEN = 16
) (
  input  logic                hclk,
  input  logic                hresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [2:0]          cmd_burst,
  input  logic                cmd_write,
  input  logic [4:0]          cmd_len,
  output logic                cmd_err,
  input  logic                wdata_valid,
  input  logic [DATA_W-1:0]   wdata,
  output logic                wdata_ready,
  output logic                enable,
  output logic [DATA_W-1:0]   din,
  output logic                hwr,
  output logic [ADDR_W-1:0]   addr,
  output logic [2:0]          bursttype,
  input  logic                hready,
  input  logic [DATA_W-1:0]   leitura,
  output logic [DATA_W-1:0]   rdata,
  output logic                rdata_valid,
  output logic                busy
);

  localparam int unsigned CntW = $clog2(WFIFO_DEPTH) + 1;

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_next;
  logic [2:0]        burst_q;
  logic              write_q;
  logic [4:0]        beats_left_q;
  logic              err_q;
  logic              rd_pend_q;
  logic              rdata_valid_q;
  logic [DATA_W-1:0] rdata_q;

  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty;
  logic [CntW-1:0]   fifo_count;

  logic              cmd_accept;
  logic              cmd_bad;
  logic              cmd_start;
  logic [4:0]        cmd_beats;
  logic [11:0]       cmd_end;
  logic [3:0]        mask;
  logic              beat_done;
  logic              fifo_pop;

  ahb_seq_wfifo #(
    .Depth (WFIFO_DEPTH)
  ) u_wfifo (
    .clk       (hclk),
    .rst       (hresetn),
    .push      (wdata_valid),
    .push_data (wdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign wdata_ready = (fifo_count != CntW'(WFIFO_DEPTH));

  // Command decode and 1KB-window check for the incrementing burst types.
  assign cmd_accept = cmd_valid && cmd_ready;
  assign cmd_beats  = burst_beats(cmd_burst, cmd_len);
  assign cmd_end    = {2'b00, cmd_addr[9:0]} + {7'd0, cmd_beats} - 12'd1;

  always_comb begin
    cmd_bad = 1'b0;
    if (cmd_burst == BURST_INCR &&
        (cmd_len == 5'd0 || {27'd0, cmd_len} > MAX_INCR_LEN)) begin
      cmd_bad = 1'b1;
    end
    if (!is_wrap(cmd_burst) && cmd_end > {1'b0, SLAVE_BOUNDARY}) begin
      cmd_bad = 1'b1;
    end
  end

  assign cmd_start = cmd_accept && !cmd_bad;
  assign beat_done = enable && hready;
  assign fifo_pop  = beat_done && write_q;

  // Bit 10 (slave select) is never touched; wraps rotate only the masked bits.
  assign mask = wrap_mask(burst_q);

  always_comb begin
    addr_next = addr_q;
    if (is_wrap(burst_q)) begin
      addr_next[3:0] = (addr_q[3:0] & ~mask) | ((addr_q[3:0] + 4'd1) & mask);
    end else begin
      addr_next[9:0] = addr_q[9:0] + 10'd1;
    end
  end

  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (cmd_start) begin
          state_d = StBeat;
        end
      end
      StBeat: begin
        if (write_q && fifo_empty) begin
          state_d = StWstall;
        end else if (beat_done && beats_left_q == 5'd1) begin
          state_d = StDone;
        end
      end
      StWstall: begin
        if (!fifo_empty) begin
          state_d = StBeat;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    enable    = 1'b0;
    case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      StBeat:  enable = !(write_q && fifo_empty);
      default: ;
    endcase
  end

  assign din         = (enable && write_q) ? fifo_head : '0;
  assign hwr         = write_q;
  assign addr        = addr_q;
  assign bursttype   = burst_q;
  assign cmd_err     = err_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      addr_q        <= '0;
      burst_q       <= '0;
      write_q       <= 1'b0;
      beats_left_q  <= '0;
      err_q         <= 1'b0;
      rd_pend_q     <= 1'b0;
      rdata_valid_q <= 1'b0;
      rdata_q       <= '0;
    end else begin
      err_q <= cmd_accept && cmd_bad;
      if (cmd_start) begin
        addr_q       <= cmd_addr;
        burst_q      <= cmd_burst;
        write_q      <= cmd_write;
        beats_left_q <= cmd_beats;
      end else if (beat_done) begin
        addr_q       <= addr_next;
        beats_left_q <= beats_left_q - 5'd1;
      end
      // Read data arrives in the data phase, one cycle after the beat completes.
      rd_pend_q     <= beat_done && !write_q;
      rdata_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        rdata_q <= leitura;
      end
    end
  end

endmodule

// File: tb/tb_ahb_burst_sequencer.sv
// Directed bench for ahb_burst_sequencer with a data-phase read slave model.
module tb_ahb_burst_sequencer;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_addr;
  logic [2:0]  cmd_burst;
  logic        cmd_write;
  logic [4:0]  cmd_len;
  logic        cmd_err;
  logic        wdata_valid;
  logic [7:0]  wdata;
  logic        wdata_ready;
  logic        enable;
  logic [7:0]  din;
  logic        hwr;
  logic [10:0] addr;
  logic [2:0]  bursttype;
  logic        hready;
  logic [7:0]  leitura;
  logic [7:0]  rdata;
  logic        rdata_valid;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] dp_addr = '0;
  logic [7:0]  rd_q[$];

  always #5 hclk = ~hclk;

  ahb_burst_sequencer #(
    .WFIFO_DEPTH  (8),
    .MAX_INCR_LEN (16)
  ) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_burst   (cmd_burst),
    .cmd_write   (cmd_write),
    .cmd_len     (cmd_len),
    .cmd_err     (cmd_err),
    .wdata_valid (wdata_valid),
    .wdata       (wdata),
    .wdata_ready (wdata_ready),
    .enable      (enable),
    .din         (din),
    .hwr         (hwr),
    .addr        (addr),
    .bursttype   (bursttype),
    .hready      (hready),
    .leitura     (leitura),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .busy        (busy)
  );

  // Slave returns the low byte of the address whose beat completed last edge.
  always @(posedge hclk) if (enable && hready) dp_addr <= addr;
  assign leitura = dp_addr[7:0];

  always @(posedge hclk) if (rdata_valid) rd_q.push_back(rdata);

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    wdata_valid = 1'b1;
    wdata       = b;
    tick();
    wdata_valid = 1'b0;
  endtask

  task automatic issue(input logic [10:0] a, input logic [2:0] bt, input logic w,
                       input logic [4:0] len);
    cmd_addr  = a;
    cmd_burst = bt;
    cmd_write = w;
    cmd_len   = len;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    hresetn = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({cmd_ready, wdata_ready, enable, hwr, busy, cmd_err, rdata_valid} !== 7'b1100000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 1100000",
               {cmd_ready, wdata_ready, enable, hwr, busy, cmd_err, rdata_valid});
    end
    n_checks++;
    if ({addr, din, bursttype, rdata} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h din=%h bt=%h rdata=%h expected all 0",
               addr, din, bursttype, rdata);
    end
    hresetn = 1'b0;
    tick();
  endtask

  task automatic test_incr4_write();
    logic [7:0] exp_d [4];
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) push_byte(exp_d[i]);
    issue(11'h005, 3'b011, 1'b1, 5'd0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({enable, hwr, addr, din, bursttype} !== {1'b1, 1'b1, 11'h005 + 11'(i), exp_d[i], 3'b011}) begin
        n_fail++;
        $display("FAIL incr4_beat%0d: got en=%b hwr=%b addr=%h din=%h bt=%h expected 1 1 %h %h 3",
                 i, enable, hwr, addr, din, bursttype, 11'h005 + 11'(i), exp_d[i]);
      end
      tick();
    end
    n_checks++;
    if ({enable, busy, cmd_ready} !== 3'b010) begin
      n_fail++;
      $display("FAIL incr4_done: got en/busy/rdy=%b expected 010", {enable, busy, cmd_ready});
    end
    tick();
    n_checks++;
    if ({busy, cmd_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL incr4_idle: got busy/rdy=%b expected 01", {busy, cmd_ready});
    end
  endtask

  task automatic test_wrap8_read();
    logic [10:0] ea;
    rd_q.delete();
    issue(11'h40E, 3'b100, 1'b0, 5'd0);
    for (int i = 0; i < 8; i++) begin
      ea = 11'h408 | 11'((6 + i) % 8);
      n_checks++;
      if ({enable, hwr, addr} !== {1'b1, 1'b0, ea}) begin
        n_fail++;
        $display("FAIL wrap8_beat%0d: got en=%b hwr=%b addr=%h expected 1 0 %h",
                 i, enable, hwr, addr, ea);
      end
      tick();
    end
    tick();
    tick();
    tick();
    n_checks++;
    if (rd_q.size() !== 8) begin
      n_fail++;
      $display("FAIL wrap8_rcount: got %0d expected 8", rd_q.size());
    end
    for (int i = 0; i < 8 && i < rd_q.size(); i++) begin
      n_checks++;
      if (rd_q[i] !== (8'h08 | 8'((6 + i) % 8))) begin
        n_fail++;
        $display("FAIL wrap8_rdata%0d: got %h expected %h", i, rd_q[i], 8'h08 | 8'((6 + i) % 8));
      end
    end
  endtask

  task automatic test_hready_stall();
    logic [7:0] exp_d [4];
    exp_d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < 4; i++) push_byte(exp_d[i]);
    issue(11'h100, 3'b011, 1'b1, 5'd0);
    n_checks++;
    if ({enable, addr, din} !== {1'b1, 11'h100, 8'hAA}) begin
      n_fail++;
      $display("FAIL stall_beat0: got en=%b addr=%h din=%h expected 1 100 aa", enable, addr, din);
    end
    tick();
    hready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({enable, addr, din} !== {1'b1, 11'h101, 8'hBB}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got en=%b addr=%h din=%h expected 1 101 bb",
                 c, enable, addr, din);
      end
      tick();
    end
    hready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if ({enable, addr, din} !== {1'b1, 11'h100 + 11'(i), exp_d[i]}) begin
        n_fail++;
        $display("FAIL stall_beat%0d: got en=%b addr=%h din=%h expected 1 %h %h",
                 i, enable, addr, din, 11'h100 + 11'(i), exp_d[i]);
      end
      tick();
    end
    tick();
    // FIFO must now be empty: exactly eight more pushes fill it.
    for (int i = 0; i < 8; i++) push_byte(8'hF0 + 8'(i));
    n_checks++;
    if (wdata_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_full: got wdata_ready=%b expected 0", wdata_ready);
    end
    push_byte(8'h99);
    issue(11'h200, 3'b101, 1'b1, 5'd0);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({enable, addr, din} !== {1'b1, 11'h200 + 11'(i), 8'hF0 + 8'(i)}) begin
        n_fail++;
        $display("FAIL drain_beat%0d: got en=%b addr=%h din=%h expected 1 %h %h",
                 i, enable, addr, din, 11'h200 + 11'(i), 8'hF0 + 8'(i));
      end
      tick();
    end
    tick();
    n_checks++;
    if ({wdata_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL drain_end: got ready/busy=%b expected 10", {wdata_ready, busy});
    end
  endtask

  task automatic test_reject();
    logic [10:0] va [3];
    logic [2:0]  vb [3];
    logic [4:0]  vl [3];
    va = '{11'h3FC, 11'h010, 11'h020};
    vb = '{3'b101, 3'b001, 3'b001};
    vl = '{5'd0, 5'd0, 5'd17};
    for (int v = 0; v < 3; v++) begin
      issue(va[v], vb[v], 1'b0, vl[v]);
      n_checks++;
      if ({cmd_err, cmd_ready, enable, busy} !== 4'b1100) begin
        n_fail++;
        $display("FAIL reject%0d_pulse: got err/rdy/en/busy=%b expected 1100",
                 v, {cmd_err, cmd_ready, enable, busy});
      end
      tick();
      n_checks++;
      if ({cmd_err, enable, busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL reject%0d_after: got err/en/busy=%b expected 000",
                 v, {cmd_err, enable, busy});
      end
    end
    // A WRAP4 ending at the window edge is accepted and wraps inside it.
    rd_q.delete();
    issue(11'h3FE, 3'b010, 1'b0, 5'd0);
    n_checks++;
    if (cmd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_edge_err: got %b expected 0", cmd_err);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({enable, addr} !== {1'b1, 11'h3FC | 11'((2 + i) % 4)}) begin
        n_fail++;
        $display("FAIL wrap_edge_beat%0d: got en=%b addr=%h expected 1 %h",
                 i, enable, addr, 11'h3FC | 11'((2 + i) % 4));
      end
      tick();
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_wstall();
    push_byte(8'h5A);
    issue(11'h020, 3'b001, 1'b1, 5'd3);
    n_checks++;
    if ({enable, addr, din} !== {1'b1, 11'h020, 8'h5A}) begin
      n_fail++;
      $display("FAIL wstall_beat0: got en=%b addr=%h din=%h expected 1 020 5a", enable, addr, din);
    end
    tick();
    n_checks++;
    if ({enable, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL wstall_empty: got en/busy=%b expected 01", {enable, busy});
    end
    tick();
    push_byte(8'h6B);
    n_checks++;
    if (enable !== 1'b0) begin
      n_fail++;
      $display("FAIL wstall_pushed: got en=%b expected 0", enable);
    end
    tick();
    n_checks++;
    if ({enable, addr, din} !== {1'b1, 11'h021, 8'h6B}) begin
      n_fail++;
      $display("FAIL wstall_resume: got en=%b addr=%h din=%h expected 1 021 6b", enable, addr, din);
    end
    push_byte(8'h7C);
    n_checks++;
    if ({enable, addr, din} !== {1'b1, 11'h022, 8'h7C}) begin
      n_fail++;
      $display("FAIL wstall_beat2: got en=%b addr=%h din=%h expected 1 022 7c", enable, addr, din);
    end
    tick();
    tick();
    n_checks++;
    if ({busy, cmd_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL wstall_idle: got busy/rdy=%b expected 01", {busy, cmd_ready});
    end
  endtask

  task automatic test_reset_midburst();
    bit seen;
    push_byte(8'h01);
    push_byte(8'h02);
    rd_q.delete();
    issue(11'h405, 3'b010, 1'b0, 5'd0);
    tick();
    n_checks++;
    if ({enable, addr} !== {1'b1, 11'h406}) begin
      n_fail++;
      $display("FAIL midrst_beat1: got en=%b addr=%h expected 1 406", enable, addr);
    end
    #2;
    hresetn = 1'b1;
    #1;
    n_checks++;
    if ({cmd_ready, wdata_ready, enable, hwr, busy, cmd_err, rdata_valid} !== 7'b1100000 ||
        {addr, din, bursttype, rdata} !== 30'd0) begin
      n_fail++;
      $display("FAIL midrst_async: got ctrl=%b addr=%h din=%h bt=%h rdata=%h expected 1100000 0 0 0 0",
               {cmd_ready, wdata_ready, enable, hwr, busy, cmd_err, rdata_valid},
               addr, din, bursttype, rdata);
    end
    tick();
    tick();
    hresetn = 1'b0;
    tick();
    tick();
    tick();
    n_checks++;
    if (rd_q.size() !== 0) begin
      n_fail++;
      $display("FAIL midrst_rvalid: got %0d pulses expected 0", rd_q.size());
    end
    // A flushed FIFO makes a SINGLE write stall until a fresh byte arrives.
    issue(11'h010, 3'b000, 1'b1, 5'd0);
    n_checks++;
    if ({enable, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL midrst_flush: got en/busy=%b expected 01", {enable, busy});
    end
    push_byte(8'h3C);
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      if (enable) seen = 1'b1;
      else tick();
    end
    n_checks++;
    if (!seen || din !== 8'h3C || addr !== 11'h010) begin
      n_fail++;
      $display("FAIL midrst_single: got seen=%b din=%h addr=%h expected 1 3c 010", seen, din, addr);
    end
    tick();
    tick();
  endtask

  initial begin
    hresetn     = 1'b1;
    cmd_valid   = 1'b0;
    cmd_addr    = '0;
    cmd_burst   = '0;
    cmd_write   = 1'b0;
    cmd_len     = '0;
    wdata_valid = 1'b0;
    wdata       = '0;
    hready      = 1'b1;
    test_reset();
    test_incr4_write();
    test_wrap8_read();
    test_hready_stall();
    test_reject();
    test_wstall();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
